// File: rtl/systolic_array_stream_pkg.sv
// Shared types and sizing helpers for the output-stationary systolic matrix multiplier.
package systolic_pkg;

  localparam int DEF_DATAWIDTH = 16;
  localparam int DEF_N_SIZE    = 4;
  localparam int DEF_ACC_WIDTH = 2*DEF_DATAWIDTH+8;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUTPUT} state_t;

  // Steps needed after the last beat for it to reach the far corner PE.
  function automatic int drain_len(input int n);
    return 2*(n-1);
  endfunction

  // Counter width able to hold 0..maxval, never narrower than one bit.
  function automatic int cnt_w(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval+1);
  endfunction

endpackage

// File: rtl/systolic_array_stream_if.sv
// Operand and result stream bundle for systolic_array_stream.
interface systolic_array_stream_if
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int N_SIZE    = DEF_N_SIZE,
  parameter int ACC_WIDTH = 2*DATAWIDTH+8
);
  logic                               in_valid;
  logic                               in_ready;
  logic                               in_last;
  logic [N_SIZE-1:0][DATAWIDTH-1:0]   matrix_a_in;
  logic [N_SIZE-1:0][DATAWIDTH-1:0]   matrix_b_in;
  logic                               out_valid;
  logic                               out_ready;
  logic                               out_last;
  logic [N_SIZE-1:0][ACC_WIDTH-1:0]   matrix_out;

  modport master (
    output in_valid, in_last, matrix_a_in, matrix_b_in, out_ready,
    input  in_ready, out_valid, out_last, matrix_out
  );

  modport slave (
    input  in_valid, in_last, matrix_a_in, matrix_b_in, out_ready,
    output in_ready, out_valid, out_last, matrix_out
  );
endinterface

// File: rtl/systolic_array_stream_pe.sv
// One multiply-accumulate cell: forwards a right and b down, accumulates a*b in place.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ACC_WIDTH = 2*DATAWIDTH+8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        clr,
  input  logic signed [DATAWIDTH-1:0] a_in,
  input  logic signed [DATAWIDTH-1:0] b_in,
  output logic signed [DATAWIDTH-1:0] a_out,
  output logic signed [DATAWIDTH-1:0] b_out,
  output logic signed [ACC_WIDTH-1:0] acc
);

  logic signed [2*DATAWIDTH-1:0] prod;

  function automatic logic signed [ACC_WIDTH-1:0] sext_prod(input logic signed [2*DATAWIDTH-1:0] p);
    return ACC_WIDTH'(p);
  endfunction

  assign prod = a_in * b_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      if (en) begin
        a_out <= a_in;
        b_out <= b_in;
      end
      if (clr)
        acc <= '0;
      else if (en)
        acc <= acc + sext_prod(prod);
    end
  end

endmodule

// File: rtl/systolic_array_stream.sv
// Output-stationary N_SIZE x N_SIZE systolic multiplier C = A x B with streamed K and row-serial output.
module systolic_array_stream
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int N_SIZE    = DEF_N_SIZE,
  parameter int ACC_WIDTH = 2*DATAWIDTH+8
) (
  input logic clk,
  input logic rst,
  systolic_array_stream_if.slave bus
);

  localparam int DRAIN_LEN = drain_len(N_SIZE);
  localparam int DW        = cnt_w(DRAIN_LEN);
  localparam int RW        = cnt_w(N_SIZE-1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_LEN > 0) ? DRAIN_LEN-1 : 0);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N_SIZE-1);

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic [RW-1:0] row;
  logic          in_ready_q, out_valid_q, out_last_q;
  logic          in_fire, adv, clr;

  logic signed [DATAWIDTH-1:0] a_inj [N_SIZE];
  logic signed [DATAWIDTH-1:0] b_inj [N_SIZE];
  // Column/row 0 of these carry the skewed edge inputs; the extra slot catches the far-edge forward.
  logic signed [DATAWIDTH-1:0] a_bus [N_SIZE][N_SIZE+1];
  logic signed [DATAWIDTH-1:0] b_bus [N_SIZE+1][N_SIZE];
  logic signed [ACC_WIDTH-1:0] acc   [N_SIZE][N_SIZE];

  assign in_fire = bus.in_valid && in_ready_q;
  assign adv     = in_fire || (state == DRAIN);
  assign clr     = out_valid_q && bus.out_ready && out_last_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

  // Drain steps inject zeros so late operands still meet partners in the far PEs.
  always_comb begin
    for (int i = 0; i < N_SIZE; i++) begin
      a_inj[i] = in_fire ? $signed(bus.matrix_a_in[i]) : '0;
      b_inj[i] = in_fire ? $signed(bus.matrix_b_in[i]) : '0;
    end
  end

  for (genvar i = 0; i < N_SIZE; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_bus[0][0] = a_inj[0];
      assign b_bus[0][0] = b_inj[0];
    end else begin : g_delay
      logic signed [DATAWIDTH-1:0] a_sr [i];
      logic signed [DATAWIDTH-1:0] b_sr [i];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < i; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else if (adv) begin
          a_sr[0] <= a_inj[i];
          b_sr[0] <= b_inj[i];
          for (int s = 1; s < i; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end

      assign a_bus[i][0] = a_sr[i-1];
      assign b_bus[0][i] = b_sr[i-1];
    end
  end

  for (genvar i = 0; i < N_SIZE; i++) begin : g_row
    for (genvar j = 0; j < N_SIZE; j++) begin : g_col
      systolic_pe #(
        .DATAWIDTH (DATAWIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .en    (adv),
        .clr   (clr),
        .a_in  (a_bus[i][j]),
        .b_in  (b_bus[i][j]),
        .a_out (a_bus[i][j+1]),
        .b_out (b_bus[i+1][j]),
        .acc   (acc[i][j])
      );
    end
  end

  always_comb begin
    bus.matrix_out = '0;
    if (out_valid_q)
      for (int j = 0; j < N_SIZE; j++)
        bus.matrix_out[j] = acc[row][j];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      drain_cnt   <= '0;
      row         <= '0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          in_ready_q <= 1'b1;
          if (in_fire) begin
            if (bus.in_last) begin
              in_ready_q <= 1'b0;
              drain_cnt  <= '0;
              if (DRAIN_LEN == 0) begin
                state       <= OUTPUT;
                out_valid_q <= 1'b1;
                out_last_q  <= (N_SIZE == 1);
                row         <= '0;
              end else begin
                state <= DRAIN;
              end
            end else begin
              state <= LOAD;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_cnt == DRAIN_LAST) begin
            state       <= OUTPUT;
            out_valid_q <= 1'b1;
            out_last_q  <= (N_SIZE == 1);
            row         <= '0;
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              state       <= IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              row         <= '0;
            end else begin
              row        <= row + RW'(1);
              out_last_q <= (row + RW'(1) == ROW_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_array_stream.sv
// Scoreboard bench for systolic_array_stream using 3x3, 2x2 and 1x1 instances.
module tb_systolic_array_stream;
  import systolic_pkg::*;

  localparam int DW  = DEF_DATAWIDTH;
  localparam int ACC = DEF_ACC_WIDTH;

  typedef struct {
    logic [ACC-1:0] v0, v1, v2;
    bit             last;
    int             lat;
  } exp_t;

  logic clk, rst;
  logic vld_d, last_d, ordy_d;
  logic [DW-1:0] a_d [3];
  logic [DW-1:0] b_d [3];
  int   sel;
  int   cyc, t0;
  int   total, bad;
  exp_t q[$];

  logic           ir_s, ov_s, ol_s;
  logic [ACC-1:0] ob [3];

  systolic_array_stream_if #(.DATAWIDTH(DW), .N_SIZE(3), .ACC_WIDTH(ACC)) if3 ();
  systolic_array_stream_if #(.DATAWIDTH(DW), .N_SIZE(2), .ACC_WIDTH(ACC)) if2 ();
  systolic_array_stream_if #(.DATAWIDTH(DW), .N_SIZE(1), .ACC_WIDTH(ACC)) if1 ();

  systolic_array_stream #(.DATAWIDTH(DW), .N_SIZE(3), .ACC_WIDTH(ACC)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  systolic_array_stream #(.DATAWIDTH(DW), .N_SIZE(2), .ACC_WIDTH(ACC)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  systolic_array_stream #(.DATAWIDTH(DW), .N_SIZE(1), .ACC_WIDTH(ACC)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if3.in_valid    = vld_d && (sel == 0);
  assign if2.in_valid    = vld_d && (sel == 1);
  assign if1.in_valid    = vld_d && (sel == 2);
  assign if3.in_last     = last_d;
  assign if2.in_last     = last_d;
  assign if1.in_last     = last_d;
  assign if3.out_ready   = ordy_d;
  assign if2.out_ready   = ordy_d;
  assign if1.out_ready   = ordy_d;
  assign if3.matrix_a_in = {a_d[2], a_d[1], a_d[0]};
  assign if3.matrix_b_in = {b_d[2], b_d[1], b_d[0]};
  assign if2.matrix_a_in = {a_d[1], a_d[0]};
  assign if2.matrix_b_in = {b_d[1], b_d[0]};
  assign if1.matrix_a_in = a_d[0];
  assign if1.matrix_b_in = b_d[0];

  always_comb begin
    ir_s = 1'b0; ov_s = 1'b0; ol_s = 1'b0;
    ob[0] = '0; ob[1] = '0; ob[2] = '0;
    case (sel)
      0: begin
        ir_s = if3.in_ready; ov_s = if3.out_valid; ol_s = if3.out_last;
        ob[0] = if3.matrix_out[0]; ob[1] = if3.matrix_out[1]; ob[2] = if3.matrix_out[2];
      end
      1: begin
        ir_s = if2.in_ready; ov_s = if2.out_valid; ol_s = if2.out_last;
        ob[0] = if2.matrix_out[0]; ob[1] = if2.matrix_out[1];
      end
      default: begin
        ir_s = if1.in_ready; ov_s = if1.out_valid; ol_s = if1.out_last;
        ob[0] = if1.matrix_out[0];
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [ACC-1:0] got, input logic [ACC-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, $signed(got), $signed(exp));
    end
  endtask

  task automatic exp_row(input int c0, input int c1, input int c2, input bit lst, input int lat);
    exp_t e;
    e.v0 = ACC'(c0); e.v1 = ACC'(c1); e.v2 = ACC'(c2);
    e.last = lst; e.lat = lat;
    q.push_back(e);
  endtask

  task automatic beat(input int a0, input int a1, input int a2,
                      input int b0, input int b1, input int b2,
                      input bit lst, input bit first);
    vld_d = 1'b1; last_d = lst;
    a_d[0] = DW'(a0); a_d[1] = DW'(a1); a_d[2] = DW'(a2);
    b_d[0] = DW'(b0); b_d[1] = DW'(b1); b_d[2] = DW'(b2);
    @(negedge clk);
    chk("beat_in_ready", ACC'(ir_s), ACC'(1));
    @(posedge clk); #1;
    if (first) t0 = cyc;
    vld_d = 1'b0; last_d = 1'b0;
  endtask

  task automatic wait_rows(input int maxc);
    for (int i = 0; i < maxc && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL rows_timeout got=%0d pending exp=0", q.size());
      q.delete();
    end
  endtask

  // Scoreboard monitor: one expected row per output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov_s && ordy_d) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_row got=%0d,%0d,%0d exp=none", $signed(ob[0]), $signed(ob[1]), $signed(ob[2]));
      end else begin
        e = q.pop_front();
        if ({ob[2], ob[1], ob[0]} !== {e.v2, e.v1, e.v0}) begin
          bad++;
          $display("FAIL row_data got=%0d,%0d,%0d exp=%0d,%0d,%0d", $signed(ob[0]), $signed(ob[1]),
                   $signed(ob[2]), $signed(e.v0), $signed(e.v1), $signed(e.v2));
        end
        total++;
        if (ol_s !== e.last) begin
          bad++;
          $display("FAIL row_last got=%0b exp=%0b", ol_s, e.last);
        end
        if (e.lat >= 0) begin
          total++;
          if (cyc - t0 + 1 != e.lat) begin
            bad++;
            $display("FAIL row_cycle got=%0d exp=%0d", cyc - t0 + 1, e.lat);
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; vld_d = 1'b0; last_d = 1'b0; ordy_d = 1'b1; sel = 0; cyc = 0; t0 = 0;
    total = 0; bad = 0;
    for (int i = 0; i < 3; i++) begin a_d[i] = '0; b_d[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", ACC'(ir_s), '0);
    chk("rst_out_valid", ACC'(ov_s), '0);
    chk("rst_out_last", ACC'(ol_s), '0);
    chk("rst_matrix_out", ob[0] | ob[1] | ob[2], '0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // 3x3 identity x B, no gaps
    exp_row(1, 2, 3, 0, 7); exp_row(4, 5, 6, 0, 8); exp_row(7, 8, 9, 1, 9);
    beat(1, 0, 0, 1, 2, 3, 0, 1);
    beat(0, 1, 0, 4, 5, 6, 0, 0);
    beat(0, 0, 1, 7, 8, 9, 1, 0);
    wait_rows(40);
    @(negedge clk);
    chk("t1_in_ready_back", ACC'(ir_s), ACC'(1));
    @(posedge clk); #1;

    // same operands, two idle cycles after beat 0
    exp_row(1, 2, 3, 0, 9); exp_row(4, 5, 6, 0, 10); exp_row(7, 8, 9, 1, 11);
    beat(1, 0, 0, 1, 2, 3, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    beat(0, 1, 0, 4, 5, 6, 0, 0);
    beat(0, 0, 1, 7, 8, 9, 1, 0);
    wait_rows(40);
    @(posedge clk); #1;

    // 2x2, K=5, all-ones A
    sel = 1;
    exp_row(15, 15, 0, 0, 7); exp_row(15, 15, 0, 1, 8);
    for (int k = 0; k < 5; k++) beat(1, 1, 0, k+1, k+1, 0, (k == 4), (k == 0));
    wait_rows(40);
    @(posedge clk); #1;

    // 2x2 signed
    exp_row(-24, 29, 0, 0, 4); exp_row(10, -12, 0, 1, 5);
    beat(-3, 1, 0, 4, -5, 0, 0, 1);
    beat(2, -1, 0, -6, 7, 0, 1, 0);
    wait_rows(40);
    @(posedge clk); #1;

    // 3x3 backpressure on row 0, then back-to-back identity op
    sel = 0; ordy_d = 1'b0;
    exp_row(5, 7, 9, 0, -1); exp_row(11, 13, 15, 0, -1); exp_row(8, 10, 12, 1, -1);
    beat(1, 0, 1, 1, 2, 3, 0, 1);
    beat(1, 1, 0, 4, 5, 6, 0, 0);
    beat(0, 1, 1, 7, 8, 9, 1, 0);
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ov_s) break;
    end
    chk("t5_valid_seen", ACC'(n < 40), ACC'(1));
    for (int s = 0; s < 3; s++) begin
      if (s > 0) @(negedge clk);
      chk("t5_hold_valid", ACC'(ov_s), ACC'(1));
      chk("t5_hold_l0", ob[0], ACC'(5));
      chk("t5_hold_l1", ob[1], ACC'(7));
      chk("t5_hold_l2", ob[2], ACC'(9));
    end
    @(posedge clk); #1 ordy_d = 1'b1;
    wait_rows(40);
    @(posedge clk); #1;
    exp_row(1, 2, 3, 0, 7); exp_row(4, 5, 6, 0, 8); exp_row(7, 8, 9, 1, 9);
    beat(1, 0, 0, 1, 2, 3, 0, 1);
    beat(0, 1, 0, 4, 5, 6, 0, 0);
    beat(0, 0, 1, 7, 8, 9, 1, 0);
    wait_rows(40);
    @(posedge clk); #1;

    // reset while the 3x3 array is draining
    beat(1, 0, 0, 1, 2, 3, 0, 1);
    beat(0, 1, 0, 4, 5, 6, 0, 0);
    beat(0, 0, 1, 7, 8, 9, 1, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_out_valid", ACC'(ov_s), '0);
    @(negedge clk);
    chk("t6_in_ready", ACC'(ir_s), ACC'(1));
    chk("t6_out_valid", ACC'(ov_s), '0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_no_row", ACC'(ov_s), '0);
    end
    @(posedge clk); #1;

    // 1x1, K=1
    sel = 2;
    exp_row(-42, 0, 0, 1, 1);
    beat(7, 0, 0, -6, 0, 0, 1, 1);
    wait_rows(20);
    @(negedge clk);
    chk("t6_n1_in_ready_back", ACC'(ir_s), ACC'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_array_stream.md
Name: systolic_array_stream

Overview:
- Parametrised output-stationary N_SIZE x N_SIZE systolic matrix multiplier computing C = A x B for signed operands.
- Successor to the fixed-schedule array:
  - a processing-element grid with internal input skew, valid/ready handshakes on both sides, and arbitrary inner dimension K marked by in_last;
  - row-serial output under backpressure;
  - correct for any N_SIZE >= 1, with no hand-unrolled cases.
- Sits between the operand streamers and the result writeback path.

Parameters:
- DATAWIDTH, 16, operand width in bits (signed two's complement).
- N_SIZE, 4, array dimension; number of A rows and B columns; valid range >= 1.
- ACC_WIDTH, 2*DATAWIDTH+8, accumulator and result width; arithmetic wraps modulo 2^ACC_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  beat k carries operand column/row k.
- in_ready  out  1  array accepts a beat.
- in_last  in  1  qualifies the final beat (k = K-1) of the operation.
- matrix_a_in  in  N_SIZE x DATAWIDTH  A[i][k] on lane i.
- matrix_b_in  in  N_SIZE x DATAWIDTH  B[k][j] on lane j.
- out_valid  out  1  a result row is presented.
- out_ready  in  1  consumer accepts a row.
- out_last  out  1  high with row N_SIZE-1.
- matrix_out  out  N_SIZE x ACC_WIDTH  row r of C, lane j = C[r][j], signed.

Behaviour:
- One clock; reset is synchronous and active-high.
- While rst is high:
  - state goes to IDLE; all accumulators, skew and forwarding registers clear to 0.
  - in_ready=0, out_valid=0, out_last=0, matrix_out=0.
- Reset mid-operation aborts the operation; no partial row is emitted.
- FSM states are IDLE, LOAD, DRAIN, OUTPUT.
  - IDLE: in_ready=1. An accepted beat goes to LOAD, or straight to DRAIN if in_last is set.
  - LOAD: in_ready=1. Each accepted beat advances the array by one step. When in_valid=0, the whole array holds (skew, forwarding, accumulators frozen), so gaps between beats are legal. An accepted beat with in_last goes to DRAIN.
  - DRAIN: in_ready=0. The array advances every cycle with zero operands injected, for exactly 2*(N_SIZE-1) cycles, then goes to OUTPUT. For N_SIZE=1 DRAIN lasts 0 cycles: LOAD/IDLE goes directly to OUTPUT.
  - OUTPUT: in_ready=0, out_valid=1, matrix_out = row r (r starts at 0). Row r advances on out_valid && out_ready. Data is stable while stalled. out_last=1 at r=N_SIZE-1. The final handshake clears all accumulators and returns to IDLE.
- Skew:
  - A lane i is delayed i steps; B lane j is delayed j steps.
  - PE(i,j) forwards a right and b down through one register each step.
  - Operand pair k meets in PE(i,j) at step k+i+j.
- PE operation: acc += sext(a)*sext(b), with the product sign-extended to ACC_WIDTH.
- Timing with no input gaps, beats accepted at cycles 0..K-1:
  - last MAC occurs at cycle K-1+2(N_SIZE-1);
  - out_valid is first high at cycle K+2(N_SIZE-1);
  - e.g. N_SIZE=4, K=4: out_valid at cycle 10.
- With out_ready held high, the N_SIZE rows occupy N_SIZE consecutive cycles.
- Ignored inputs:
  - in_last without in_valid is ignored.
  - Inputs presented while in_ready=0 are ignored, not queued.
- Minimum K is 1; there is no upper limit, since wrap is defined by ACC_WIDTH.

Decomposition:
- Package systolic_pkg:
  - DATAWIDTH/ACC_WIDTH defaults;
  - state_t enum (IDLE, LOAD, DRAIN, OUTPUT);
  - function for drain length 2*(N_SIZE-1);
  - clog2-based counter widths for K-independent step, drain and row counters.
- Sub-module systolic_pe:
  - one multiply-accumulate cell with enable, clear, registered a/b forwarding and acc output;
  - instantiated N_SIZE^2 times via generate.
- Skew registers live in the top level.

Test Plan:
- N_SIZE=3, K=3, A=identity, B=[[1,2,3],[4,5,6],[7,8,9]], no gaps, out_ready=1 -> out_valid at cycle 7, rows 1 2 3 / 4 5 6 / 7 8 9, out_last on the third row, in_ready back to 1 the next cycle.
- Same operands with in_valid low for 2 cycles between beats 0 and 1 -> identical rows, first out_valid delayed by exactly 2 cycles.
- N_SIZE=2, K=5, A rows all 1s, B[k][*]=k+1 -> every C entry 15; tests in_last-terminated inner dimension > N_SIZE.
- Signed: N_SIZE=2, K=2, A=[[-3,2],[1,-1]], B=[[4,-5],[-6,7]] -> C=[[-24,29],[10,-12]], sign-extended to ACC_WIDTH.
- Backpressure: out_ready low 3 cycles while row 0 is presented -> matrix_out stable, out_valid held, no row skipped; then back-to-back second operation with accumulators starting from 0.
- rst pulsed during DRAIN -> next cycle in_ready=1, out_valid=0; a new K=1 operation with N_SIZE=1 (a=7, b=-6) -> out_valid at cycle 1 with matrix_out=-42.
